// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: PC generation, bus fetch, one-entry skid buffer and IF/ID register.
// Optional macro IF_PERF_CNT_EN adds saturating FetchCnt/BubbleCnt outputs.
module if_fetch_stage #(
  parameter int                     WORD_ADDR_W  = 30,
  parameter int                     WORD_DATA_W  = 32,
  parameter logic [WORD_ADDR_W-1:0] RESET_VECTOR = 30'h0,
  parameter logic [WORD_DATA_W-1:0] NOP_INSN     = 32'h0
) (
  input  logic                   Clk,
  input  logic                   Reset_,
  input  logic                   Stall,
  input  logic                   Flush,
  input  logic [WORD_ADDR_W-1:0] NewPC,
  input  logic                   BrTaken,
  input  logic [WORD_ADDR_W-1:0] BrAddr,
  output logic                   BusReq,
  output logic [WORD_ADDR_W-1:0] BusAddr,
  input  logic                   BusRdy,
  input  logic [WORD_DATA_W-1:0] BusRdData,
  output logic [WORD_ADDR_W-1:0] IFPC,
  output logic [WORD_DATA_W-1:0] IFInsn,
`ifdef IF_PERF_CNT_EN
  output logic [31:0]            FetchCnt,
  output logic [31:0]            BubbleCnt,
`endif
  output logic                   IFEn
);

  typedef enum logic [0:0] {FETCH = 1'b0, HOLD = 1'b1} state_t;

  state_t                 state_r, state_s;
  logic [WORD_ADDR_W-1:0] pc_r, pc_s;
  logic [WORD_ADDR_W-1:0] ifpc_r, ifpc_s;
  logic [WORD_DATA_W-1:0] insn_r, insn_s;
  logic                   ifen_r, ifen_s;
  logic [WORD_ADDR_W-1:0] skid_pc_r, skid_pc_s;
  logic [WORD_DATA_W-1:0] skid_insn_r, skid_insn_s;
  logic                   pend_v_r, pend_v_s;
  logic [WORD_ADDR_W-1:0] pend_addr_r, pend_addr_s;
  logic [WORD_ADDR_W-1:0] target_s;
  logic                   deliver_s;
  logic                   bubble_s;

  // Next PC after a completed fetch: a live branch beats a latched one, else sequential.
  always_comb begin
    if (BrTaken) begin
      target_s = BrAddr;
    end else if (pend_v_r) begin
      target_s = pend_addr_r;
    end else begin
      target_s = pc_r + {{(WORD_ADDR_W-1){1'b0}}, 1'b1};
    end
  end

  // Next-state and IF/ID update logic.
  always_comb begin
    state_s     = state_r;
    pc_s        = pc_r;
    ifpc_s      = ifpc_r;
    insn_s      = insn_r;
    ifen_s      = ifen_r;
    skid_pc_s   = skid_pc_r;
    skid_insn_s = skid_insn_r;
    pend_v_s    = pend_v_r;
    pend_addr_s = pend_addr_r;
    deliver_s   = 1'b0;
    bubble_s    = 1'b0;
    if (Flush) begin
      state_s  = FETCH;
      pc_s     = NewPC;
      ifen_s   = 1'b0;
      insn_s   = NOP_INSN;
      pend_v_s = 1'b0;
    end else begin
      case (state_r)
        FETCH: begin
          if (BusRdy) begin
            pc_s     = target_s;
            pend_v_s = 1'b0;
            if (Stall) begin
              skid_pc_s   = pc_r;
              skid_insn_s = BusRdData;
              state_s     = HOLD;
            end else begin
              ifpc_s    = pc_r;
              insn_s    = BusRdData;
              ifen_s    = 1'b1;
              deliver_s = 1'b1;
            end
          end else begin
            if (!Stall) begin
              ifen_s   = 1'b0;
              insn_s   = NOP_INSN;
              bubble_s = 1'b1;
            end else begin
              ifen_s = ifen_r;
            end
            if (BrTaken) begin
              pend_v_s    = 1'b1;
              pend_addr_s = BrAddr;
            end else begin
              pend_v_s = pend_v_r;
            end
          end
        end
        HOLD: begin
          if (!Stall) begin
            ifpc_s    = skid_pc_r;
            insn_s    = skid_insn_r;
            ifen_s    = 1'b1;
            state_s   = FETCH;
            deliver_s = 1'b1;
            if (BrTaken) begin
              pc_s = BrAddr;
            end else begin
              pc_s = pc_r;
            end
          end else begin
            state_s = HOLD;
          end
        end
        default: begin
          state_s = FETCH;
        end
      endcase
    end
  end

  // State, PC, skid and IF/ID registers.
  always_ff @(posedge Clk) begin
    if (!Reset_) begin
      state_r     <= FETCH;
      pc_r        <= RESET_VECTOR;
      ifpc_r      <= {WORD_ADDR_W{1'b0}};
      insn_r      <= NOP_INSN;
      ifen_r      <= 1'b0;
      skid_pc_r   <= {WORD_ADDR_W{1'b0}};
      skid_insn_r <= NOP_INSN;
      pend_v_r    <= 1'b0;
      pend_addr_r <= {WORD_ADDR_W{1'b0}};
    end else begin
      state_r     <= state_s;
      pc_r        <= pc_s;
      ifpc_r      <= ifpc_s;
      insn_r      <= insn_s;
      ifen_r      <= ifen_s;
      skid_pc_r   <= skid_pc_s;
      skid_insn_r <= skid_insn_s;
      pend_v_r    <= pend_v_s;
      pend_addr_r <= pend_addr_s;
    end
  end

  // Request is masked while reset is held so a stale transaction is never issued.
  assign BusReq  = (state_r == FETCH) && Reset_;
  assign BusAddr = pc_r;
  assign IFPC    = ifpc_r;
  assign IFInsn  = insn_r;
  assign IFEn    = ifen_r;

`ifdef IF_PERF_CNT_EN
  logic [31:0] fetch_cnt_r;
  logic [31:0] bubble_cnt_r;

  // Saturating performance counters, cleared by reset or flush.
  always_ff @(posedge Clk) begin
    if (!Reset_ || Flush) begin
      fetch_cnt_r  <= 32'h0;
      bubble_cnt_r <= 32'h0;
    end else begin
      if (deliver_s && (fetch_cnt_r != 32'hFFFF_FFFF)) begin
        fetch_cnt_r <= fetch_cnt_r + 32'd1;
      end else begin
        fetch_cnt_r <= fetch_cnt_r;
      end
      if (bubble_s && (bubble_cnt_r != 32'hFFFF_FFFF)) begin
        bubble_cnt_r <= bubble_cnt_r + 32'd1;
      end else begin
        bubble_cnt_r <= bubble_cnt_r;
      end
    end
  end

  assign FetchCnt  = fetch_cnt_r;
  assign BubbleCnt = bubble_cnt_r;
`else
  logic unused_s;
  assign unused_s = deliver_s ^ bubble_s;
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed self-checking bench for if_fetch_stage; the bus returns data equal to its word address.
module tb_if_fetch_stage;
  logic        Clk = 1'b0;
  logic        Reset_, Stall, Flush, BrTaken, BusRdy;
  logic [29:0] NewPC, BrAddr;
  logic        BusReq, IFEn;
  logic [29:0] BusAddr, IFPC;
  logic [31:0] BusRdData, IFInsn;
`ifdef IF_PERF_CNT_EN
  logic [31:0] FetchCnt, BubbleCnt;
`endif
  int vectors = 0;
  int miscompares = 0;

  if_fetch_stage #(.WORD_ADDR_W(30), .WORD_DATA_W(32), .RESET_VECTOR(30'h100), .NOP_INSN(32'h0)) dut (
    .Clk(Clk), .Reset_(Reset_), .Stall(Stall), .Flush(Flush), .NewPC(NewPC),
    .BrTaken(BrTaken), .BrAddr(BrAddr), .BusReq(BusReq), .BusAddr(BusAddr),
    .BusRdy(BusRdy), .BusRdData(BusRdData), .IFPC(IFPC), .IFInsn(IFInsn),
`ifdef IF_PERF_CNT_EN
    .FetchCnt(FetchCnt), .BubbleCnt(BubbleCnt),
`endif
    .IFEn(IFEn));

  always #5 Clk = ~Clk;
  assign BusRdData = {2'b00, BusAddr};

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    // single comparison site kept inline per caller via this thin wrapper is avoided; see tasks
  endtask

  task automatic test_reset();
    Reset_ = 1'b0; Stall = 1'b0; Flush = 1'b0; BrTaken = 1'b0; BusRdy = 1'b1;
    NewPC = 30'h0; BrAddr = 30'h0;
    tick(); tick();
    vectors++; if (IFEn !== 1'b0) begin miscompares++; $display("FAIL reset_ifen got %0h want 0", IFEn); end
    vectors++; if (IFPC !== 30'h0) begin miscompares++; $display("FAIL reset_ifpc got %0h want 0", IFPC); end
    vectors++; if (IFInsn !== 32'h0) begin miscompares++; $display("FAIL reset_insn got %0h want 0", IFInsn); end
    vectors++; if (BusReq !== 1'b0) begin miscompares++; $display("FAIL reset_busreq got %0h want 0", BusReq); end
    vectors++; if (BusAddr !== 30'h100) begin miscompares++; $display("FAIL reset_busaddr got %0h want 100", BusAddr); end
  endtask

  task automatic test_sequential();
    Reset_ = 1'b1;
    #1;
    vectors++; if (BusReq !== 1'b1) begin miscompares++; $display("FAIL first_busreq got %0h want 1", BusReq); end
    for (int i = 0; i < 4; i++) begin
      tick();
      vectors++; if (IFPC !== 30'h100 + 30'(i)) begin miscompares++; $display("FAIL seq_ifpc[%0d] got %0h want %0h", i, IFPC, 30'h100 + 30'(i)); end
      vectors++; if (IFEn !== 1'b1 || IFInsn !== 32'h100 + 32'(i)) begin miscompares++; $display("FAIL seq_insn[%0d] got en=%0h insn=%0h want en=1 insn=%0h", i, IFEn, IFInsn, 32'h100 + 32'(i)); end
    end
    vectors++; if (BusAddr !== 30'h104) begin miscompares++; $display("FAIL seq_busaddr got %0h want 104", BusAddr); end
  endtask

  task automatic test_bus_wait();
    BusRdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      vectors++; if (IFEn !== 1'b0 || IFInsn !== 32'h0) begin miscompares++; $display("FAIL wait_bubble[%0d] got en=%0h insn=%0h want en=0 insn=0", i, IFEn, IFInsn); end
      vectors++; if (BusReq !== 1'b1 || BusAddr !== 30'h104) begin miscompares++; $display("FAIL wait_req[%0d] got req=%0h addr=%0h want req=1 addr=104", i, BusReq, BusAddr); end
    end
    BusRdy = 1'b1;
    tick();
    vectors++; if (IFPC !== 30'h104 || IFEn !== 1'b1) begin miscompares++; $display("FAIL wait_done got pc=%0h en=%0h want pc=104 en=1", IFPC, IFEn); end
  endtask

  task automatic test_branch();
    BrTaken = 1'b1; BrAddr = 30'h200;
    tick();
    BrTaken = 1'b0;
    vectors++; if (IFPC !== 30'h105 || IFInsn !== 32'h105) begin miscompares++; $display("FAIL br_delay_slot got pc=%0h insn=%0h want 105", IFPC, IFInsn); end
    vectors++; if (BusAddr !== 30'h200) begin miscompares++; $display("FAIL br_busaddr got %0h want 200", BusAddr); end
    tick();
    vectors++; if (IFPC !== 30'h200) begin miscompares++; $display("FAIL br_target got %0h want 200", IFPC); end
  endtask

  task automatic test_stall_skid();
    Stall = 1'b1;
    tick();
    vectors++; if (BusReq !== 1'b0 || IFPC !== 30'h200 || IFEn !== 1'b1) begin miscompares++; $display("FAIL stall1 got req=%0h pc=%0h en=%0h want req=0 pc=200 en=1", BusReq, IFPC, IFEn); end
    tick();
    vectors++; if (BusReq !== 1'b0 || IFPC !== 30'h200) begin miscompares++; $display("FAIL stall2 got req=%0h pc=%0h want req=0 pc=200", BusReq, IFPC); end
    Stall = 1'b0;
    tick();
    vectors++; if (IFPC !== 30'h201 || IFInsn !== 32'h201 || IFEn !== 1'b1) begin miscompares++; $display("FAIL skid_out got pc=%0h insn=%0h en=%0h want 201", IFPC, IFInsn, IFEn); end
    vectors++; if (BusReq !== 1'b1 || BusAddr !== 30'h202) begin miscompares++; $display("FAIL skid_resume got req=%0h addr=%0h want req=1 addr=202", BusReq, BusAddr); end
    tick();
    vectors++; if (IFPC !== 30'h202) begin miscompares++; $display("FAIL skid_next got %0h want 202", IFPC); end
  endtask

  task automatic test_flush_skid();
    Stall = 1'b1;
    tick();
    Flush = 1'b1; NewPC = 30'h040;
    tick();
    Flush = 1'b0; Stall = 1'b0;
    vectors++; if (IFEn !== 1'b0 || IFInsn !== 32'h0) begin miscompares++; $display("FAIL flush_ifid got en=%0h insn=%0h want 0", IFEn, IFInsn); end
    vectors++; if (BusReq !== 1'b1 || BusAddr !== 30'h040) begin miscompares++; $display("FAIL flush_addr got req=%0h addr=%0h want req=1 addr=40", BusReq, BusAddr); end
    tick();
    vectors++; if (IFPC !== 30'h040 || IFEn !== 1'b1) begin miscompares++; $display("FAIL flush_next got pc=%0h en=%0h want pc=40 en=1", IFPC, IFEn); end
  endtask

  task automatic test_pending_branch();
    Flush = 1'b1; NewPC = 30'h110;
    tick();
    Flush = 1'b0; BusRdy = 1'b0; BrTaken = 1'b1; BrAddr = 30'h300;
    tick();
    BrTaken = 1'b0;
    vectors++; if (BusAddr !== 30'h110 || IFEn !== 1'b0) begin miscompares++; $display("FAIL pend_hold got addr=%0h en=%0h want addr=110 en=0", BusAddr, IFEn); end
    tick();
    BusRdy = 1'b1;
    tick();
    vectors++; if (IFPC !== 30'h110 || IFEn !== 1'b1) begin miscompares++; $display("FAIL pend_deliver got pc=%0h en=%0h want pc=110 en=1", IFPC, IFEn); end
    vectors++; if (BusAddr !== 30'h300) begin miscompares++; $display("FAIL pend_target got %0h want 300", BusAddr); end
    tick();
    vectors++; if (IFPC !== 30'h300) begin miscompares++; $display("FAIL pend_ifpc got %0h want 300", IFPC); end
  endtask

  task automatic test_wrap();
    Flush = 1'b1; NewPC = 30'h3FFF_FFFF;
    tick();
    Flush = 1'b0;
    tick();
    vectors++; if (IFPC !== 30'h3FFF_FFFF || BusAddr !== 30'h0) begin miscompares++; $display("FAIL wrap got pc=%0h addr=%0h want pc=3fffffff addr=0", IFPC, BusAddr); end
    tick();
    vectors++; if (IFPC !== 30'h0) begin miscompares++; $display("FAIL wrap_next got %0h want 0", IFPC); end
  endtask

  task automatic test_reset_mid();
    BusRdy = 1'b0;
    tick();
    Reset_ = 1'b0;
    tick();
    BusRdy = 1'b1;
    #1;
    vectors++; if (BusReq !== 1'b0 || IFEn !== 1'b0) begin miscompares++; $display("FAIL midreset got req=%0h en=%0h want 0", BusReq, IFEn); end
    tick();
    Reset_ = 1'b1;
    #1;
    vectors++; if (BusAddr !== 30'h100 || IFPC !== 30'h0 || BusReq !== 1'b1) begin miscompares++; $display("FAIL midreset_release got addr=%0h pc=%0h req=%0h want addr=100 pc=0 req=1", BusAddr, IFPC, BusReq); end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_bus_wait();
    test_branch();
    test_stall_skid();
    test_flush_skid();
    test_pending_branch();
    test_wrap();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
